// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg : shared constants for the stack CPU (sizes, opcodes, ALU controls)
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int DEPTH_DEF = 16;

  // Opcodes, shared with the decoder
  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_PUSH   = 4'h1;
  localparam logic [3:0] OP_POP    = 4'h2;
  localparam logic [3:0] OP_ADD    = 4'h3;
  localparam logic [3:0] OP_SUB    = 4'h4;
  localparam logic [3:0] OP_AND    = 4'h5;
  localparam logic [3:0] OP_OR     = 4'h6;
  localparam logic [3:0] OP_XOR    = 4'h7;
  localparam logic [3:0] OP_LOAD   = 4'h8;
  localparam logic [3:0] OP_STORE  = 4'h9;
  localparam logic [3:0] OP_JMP    = 4'hA;
  localparam logic [3:0] OP_JZ     = 4'hB;
  localparam logic [3:0] OP_CALL   = 4'hC;
  localparam logic [3:0] OP_POP_PC = 4'hD;
  localparam logic [3:0] OP_DUP    = 4'hE;
  localparam logic [3:0] OP_HALT   = 4'hF;

  // ALU control encodings
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_PASS = 3'd5;

endpackage : cpu_pkg

`default_nettype wire

// File: rtl/stack_ptr_ctl.sv
// ----------------------------------------------------------------------------
// stack_ptr_ctl : next stack pointer, write index/enable and error detection
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module stack_ptr_ctl
  import cpu_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int PTR_W = $clog2(DEPTH + 1)
) (
  input  logic             read_reg1,
  input  logic             read_reg2,
  input  logic             write_reg,
  input  logic [PTR_W-1:0] sp_q_i,
  output logic [PTR_W-1:0] sp_d_o,
  output logic [PTR_W-1:0] wr_idx_o,
  output logic             wr_en_o,
  output logic             set_uflow_o,
  output logic             set_oflow_o
);

  localparam logic [PTR_W:0] DEPTH_X = (PTR_W + 1)'(DEPTH);

  // One extra bit keeps the depth comparison free of wrap-around
  logic [PTR_W:0] npop;
  logic [PTR_W:0] npush;
  logic [PTR_W:0] base;
  logic [PTR_W:0] sum;
  logic           uflow;
  logic           oflow;
  logic           legal;

  always_comb begin
    npop  = read_reg2 ? (PTR_W + 1)'(2) : (read_reg1 ? (PTR_W + 1)'(1) : '0);
    npush = write_reg ? (PTR_W + 1)'(1) : '0;
    base  = {1'b0, sp_q_i} - npop;
    sum   = base + npush;
    uflow = npop > {1'b0, sp_q_i};
    oflow = !uflow && (sum > DEPTH_X);
    legal = !uflow && !oflow;

    sp_d_o      = legal ? sum[PTR_W-1:0] : sp_q_i;
    wr_idx_o    = base[PTR_W-1:0];
    wr_en_o     = legal && write_reg;
    set_uflow_o = uflow;
    set_oflow_o = oflow;
  end

endmodule : stack_ptr_ctl

`default_nettype wire

// File: rtl/stack_regfile.sv
// ----------------------------------------------------------------------------
// stack_regfile : register-based operand stack, top two entries read combinationally
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module stack_regfile
  import cpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int PTR_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             read_reg1,
  input  logic             read_reg2,
  input  logic             write_reg,
  input  logic [WIDTH-1:0] write_data,
  output logic [WIDTH-1:0] top1,
  output logic [WIDTH-1:0] top2,
  output logic [PTR_W-1:0] sp,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] sp_q;
  logic [PTR_W-1:0] sp_d;
  logic [PTR_W-1:0] wr_idx;
  logic             wr_en;
  logic             set_uflow;
  logic             set_oflow;
  logic             oflow_q;
  logic             uflow_q;

  stack_ptr_ctl #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ptr_ctl (
    .read_reg1   (read_reg1),
    .read_reg2   (read_reg2),
    .write_reg   (write_reg),
    .sp_q_i      (sp_q),
    .sp_d_o      (sp_d),
    .wr_idx_o    (wr_idx),
    .wr_en_o     (wr_en),
    .set_uflow_o (set_uflow),
    .set_oflow_o (set_oflow)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sp_q    <= '0;
      oflow_q <= 1'b0;
      uflow_q <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      oflow_q <= oflow_q | set_oflow;
      uflow_q <= uflow_q | set_uflow;
    end
  end

  // Contents are never cleared; reset only suppresses the write
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (reset_n && wr_en && (wr_idx == PTR_W'(i))) begin
        mem_q[i] <= write_data;
      end
    end
  end

  // Matching on sp rather than indexing by sp-1/sp-2 means no wrapped read is possible
  always_comb begin
    top1 = '0;
    top2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sp_q == PTR_W'(i + 1)) top1 = mem_q[i];
      if (sp_q == PTR_W'(i + 2)) top2 = mem_q[i];
    end
  end

  assign sp        = sp_q;
  assign empty     = (sp_q == '0);
  assign full      = (sp_q == PTR_W'(DEPTH));
  assign overflow  = oflow_q;
  assign underflow = uflow_q;

endmodule : stack_regfile

`default_nettype wire

// File: tb/tb_stack_regfile.sv
// ----------------------------------------------------------------------------
// tb_stack_regfile : directed scoreboard bench for stack_regfile
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_stack_regfile;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int PTR_W = 5;

  logic             clk;
  logic             reset_n;
  logic             read_reg1;
  logic             read_reg2;
  logic             write_reg;
  logic [WIDTH-1:0] write_data;
  logic [WIDTH-1:0] top1;
  logic [WIDTH-1:0] top2;
  logic [PTR_W-1:0] sp;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  stack_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .write_reg  (write_reg),
    .write_data (write_data),
    .top1       (top1),
    .top2       (top2),
    .sp         (sp),
    .empty      (empty),
    .full       (full),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [PTR_W-1:0] sp;
    logic [WIDTH-1:0] t1;
    logic [WIDTH-1:0] t2;
    logic             e;
    logic             f;
    logic             o;
    logic             u;
  } exp_t;

  exp_t sbq[$];

  // Reference model state
  int               m_sp;
  logic [WIDTH-1:0] m_mem [DEPTH];
  logic             m_ovf;
  logic             m_unf;

  int checks;
  int errors;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic rn, input logic r1, input logic r2, input logic w,
                       input logic [WIDTH-1:0] d);
    int   npop;
    int   npush;
    exp_t e;
    npop  = r2 ? 2 : (r1 ? 1 : 0);
    npush = w ? 1 : 0;
    if (!rn) begin
      m_sp  = 0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (npop > m_sp) begin
      m_unf = 1'b1;
    end else if (m_sp - npop + npush > DEPTH) begin
      m_ovf = 1'b1;
    end else begin
      if (w) m_mem[m_sp - npop] = d;
      m_sp = m_sp - npop + npush;
    end
    e.sp = PTR_W'(m_sp);
    e.t1 = (m_sp >= 1) ? m_mem[m_sp - 1] : '0;
    e.t2 = (m_sp >= 2) ? m_mem[m_sp - 2] : '0;
    e.e  = (m_sp == 0);
    e.f  = (m_sp == DEPTH);
    e.o  = m_ovf;
    e.u  = m_unf;
    sbq.push_back(e);
  endtask

  // Drive one cycle, predict, then compare the DUT against the oldest prediction
  task automatic step(input logic rn, input logic r1, input logic r2, input logic w,
                      input logic [WIDTH-1:0] d);
    exp_t e;
    reset_n    = rn;
    read_reg1  = r1;
    read_reg2  = r2;
    write_reg  = w;
    write_data = d;
    model(rn, r1, r2, w, d);
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    read_reg1 = 1'b0;
    read_reg2 = 1'b0;
    write_reg = 1'b0;
    if (sbq.size() == 0) begin
      errors++;
      $error("FAIL scoreboard: observed empty queue expected entry");
    end else begin
      e = sbq.pop_front();
      chk("sp",        WIDTH'(sp),        WIDTH'(e.sp));
      chk("top1",      top1,              e.t1);
      chk("top2",      top2,              e.t2);
      chk("empty",     WIDTH'(empty),     WIDTH'(e.e));
      chk("full",      WIDTH'(full),      WIDTH'(e.f));
      chk("overflow",  WIDTH'(overflow),  WIDTH'(e.o));
      chk("underflow", WIDTH'(underflow), WIDTH'(e.u));
    end
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    step(1'b1, 1'b0, 1'b0, 1'b1, d);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    m_sp       = 0;
    m_ovf      = 1'b0;
    m_unf      = 1'b0;
    reset_n    = 1'b0;
    read_reg1  = 1'b0;
    read_reg2  = 1'b0;
    write_reg  = 1'b0;
    write_data = '0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

    // Reset then idle
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk("rst_sp",    WIDTH'(sp),    32'd0);
    chk("rst_empty", WIDTH'(empty), 32'd1);
    chk("rst_top1",  top1,          32'd0);

    // Three pushes, then ADD-style pop2+push
    push(32'h11);
    push(32'h22);
    push(32'h33);
    chk("p3_sp",   WIDTH'(sp), 32'd3);
    chk("p3_top1", top1,       32'h33);
    chk("p3_top2", top2,       32'h22);
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h55);
    chk("add_sp",   WIDTH'(sp), 32'd2);
    chk("add_top1", top1,       32'h55);
    chk("add_top2", top2,       32'h11);

    // Hold with no strobes
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD);

    // Underflow from sp=1, then legal pop1 keeps the sticky flag
    step(1'b1, 1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, 1'b0, '0);
    chk("uf_flag", WIDTH'(underflow), 32'd1);
    chk("uf_sp",   WIDTH'(sp),        32'd1);
    chk("uf_top1", top1,              32'h11);
    step(1'b1, 1'b1, 1'b0, 1'b0, '0);
    chk("uf_sticky", WIDTH'(underflow), 32'd1);
    // Pop at empty: underflow again, sp stays 0
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h99);

    // Fill to DEPTH, overflow, then pop2+push while full
    for (int i = 0; i < DEPTH; i++) push(WIDTH'(i));
    chk("fill_full", WIDTH'(full), 32'd1);
    chk("fill_top1", top1,         32'd15);
    push(32'hAA);
    chk("of_flag", WIDTH'(overflow), 32'd1);
    chk("of_sp",   WIDTH'(sp),       32'd16);
    chk("of_top1", top1,             32'd15);
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'hBB);
    chk("fp_sp",   WIDTH'(sp), 32'd15);
    chk("fp_top1", top1,       32'hBB);
    chk("fp_top2", top2,       32'd13);
    // Pop1+push while full is also legal
    push(32'hCC);
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'hDD);
    chk("fp1_top1", top1, 32'hDD);

    // POP_PC-style pop1 at sp=2
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("rst2_top1", top1, 32'd0);
    chk("rst2_top2", top2, 32'd0);
    push(32'h101);
    push(32'h202);
    step(1'b1, 1'b1, 1'b0, 1'b0, '0);
    chk("pop1_sp",   WIDTH'(sp), 32'd1);
    chk("pop1_top1", top1,       32'h101);
    chk("pop1_top2", top2,       32'd0);

    // Reset mid-sequence with a pending push
    for (int i = 0; i < 4; i++) push(WIDTH'(32'h300 + i));
    chk("pre_sp", WIDTH'(sp), 32'd5);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'hEE);
    chk("mr_sp",   WIDTH'(sp), 32'd0);
    chk("mr_top1", top1,       32'd0);
    push(32'h7);
    chk("mr_push_top1", top1,       32'h7);
    chk("mr_push_sp",   WIDTH'(sp), 32'd1);
    chk("mr_push_top2", top2,       32'd0);

    if (sbq.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d left expected 0", sbq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_stack_regfile

`default_nettype wire

// File: doc/stack_regfile.md
Name: stack_regfile

Overview:
Hardware operand stack for the single-cycle stack CPU. It sits directly downstream of the opcode decoder and consumes the decoder's read_reg1/read_reg2/write_reg strobes. It exposes the top two entries combinationally to the ALU, branch and memory datapath, and commits pops and pushes at the clock edge. It tracks stack depth and flags overflow and underflow.

Parameters:
WIDTH, 32, data width of each stack entry.
DEPTH, 16, number of entries; power of two, at least 4.
PTR_W, $clog2(DEPTH+1), width of the stack pointer/count.

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  reset; synchronous, active-low.
read_reg1  in  1  pop one entry this cycle.
read_reg2  in  1  pop two entries this cycle; dominates read_reg1.
write_reg  in  1  push write_data this cycle, after the pops.
write_data  in  WIDTH  value to push (ALU result, memory data or PC, muxed upstream).
top1  out  WIDTH  entry at sp-1; 0 when sp<1.
top2  out  WIDTH  entry at sp-2; 0 when sp<2.
sp  out  PTR_W  current entry count, 0..DEPTH.
empty  out  1  sp==0.
full  out  1  sp==DEPTH.
overflow  out  1  sticky; set by a rejected push.
underflow  out  1  sticky; set by a rejected pop.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (reset_n==0 at a clk edge): sp=0, overflow=0, underflow=0. Array contents are not cleared. Consequences: top1=top2=0, empty=1, full=0. Reset overrides all strobes in the same cycle.
- Combinational outputs: top1, top2, empty and full depend only on sp and the array, never on the current strobes. Read latency is 0. Writes become visible the cycle after the edge.
- Pop count: npop = read_reg2 ? 2 : (read_reg1 ? 1 : 0).
- Push count: npush = write_reg.
- Validity checks:
  - Underflow: npop > sp.
  - Overflow: sp - npop + npush > DEPTH.
- Legal cycle (no error): at the edge, sp <= sp - npop + npush. If npush, array[sp - npop] <= write_data, so the pushed value overwrites the lowest popped slot.
- Illegal cycle:
  - No change to sp or the array.
  - Set underflow if its condition holds; otherwise set overflow if its condition holds.
  - Underflow has priority, and the two flags are never set in the same cycle.
- Flags are sticky until reset. No other clear exists.
- Simultaneous pop and push while full is legal (e.g. pop2 and push1 at sp==DEPTH gives sp=DEPTH-1). Push alone when full sets overflow.
- No strobes: all state holds.
- Reset asserted mid-sequence: the next cycle sees sp=0 regardless of pending strobes. Stale array data must never appear on top1/top2.
- Index arithmetic uses PTR_W-bit unsigned values. Index sp-1 and sp-2 are computed only when valid, so no wrap-around reads occur.
- Single write port, two combinational read ports. The array is inferred as registers; no RAM macro is used.

Decomposition:
- Shared package cpu_pkg holds:
  - the WIDTH and DEPTH defaults;
  - the opcode localparams shared with the decoder;
  - the ALU control encoding constants.
- No typedefs are required.
- One sub-module is natural: stack_ptr_ctl. It computes npop, npush, next sp, the write index, write enable and the error flags. The stack_regfile top holds the array and read muxing.

Test Plan:
1. Reset then idle -> sp=0, empty=1, top1=0, top2=0, overflow=underflow=0.
2. Push 0x11, 0x22, 0x33 on consecutive cycles -> sp=3, top1=0x33, top2=0x22. Then pop2+push 0x55 (ADD-style) -> sp=2, top1=0x55, top2=0x11.
3. From sp=1, assert read_reg2 -> underflow=1, sp stays 1, top1 unchanged. A later legal pop1 -> sp=0, underflow stays 1.
4. Fill to DEPTH=16 with values 0..15 -> full=1, top1=15. Push 0xAA -> overflow=1, sp=16, top1=15. Pop2+push 0xBB -> sp=15, top1=0xBB, top2=13.
5. Pop1 only (POP_PC-style) at sp=2 -> sp=1, top1 = former top2, top2=0.
6. At sp=5, assert reset_n=0 together with write_reg=1 -> next cycle sp=0, top1=0. Push 0x7 -> top1=0x7, sp=1.
